// File: rtl/calendar_pkg.sv
// Shared calendar definitions: alarm state encoding, time/date field widths,
// day-of-week codes and the packed date layout used across calendar blocks.
package calendar_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int DOW_W  = 3;
  localparam int DAYS_W = 7;

  localparam logic [DOW_W-1:0] SUN = 3'd0;
  localparam logic [DOW_W-1:0] MON = 3'd1;
  localparam logic [DOW_W-1:0] TUE = 3'd2;
  localparam logic [DOW_W-1:0] WED = 3'd3;
  localparam logic [DOW_W-1:0] THU = 3'd4;
  localparam logic [DOW_W-1:0] FRI = 3'd5;
  localparam logic [DOW_W-1:0] SAT = 3'd6;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZED
  } alarm_state_t;

  // year[22:9], month[8:5], day[4:0]
  typedef struct packed {
    logic [13:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
  } date_t;

endpackage

// File: rtl/alarm_bank_if.sv
// Configuration and user-control bus into the alarm bank.
interface alarm_bank_if
  import calendar_pkg::*;
#(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [HOUR_W-1:0] cfg_hour;
  logic [MIN_W-1:0]  cfg_min;
  logic [DAYS_W-1:0] cfg_days;
  logic              cfg_en;
  logic              ack;
  logic              snooze;

  modport master (
    output cfg_we, cfg_ch, cfg_hour, cfg_min, cfg_days, cfg_en, ack, snooze
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_hour, cfg_min, cfg_days, cfg_en, ack, snooze
  );
endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: programmed time/day mask, ring timeout and snooze countdown.
module alarm_channel
  import calendar_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] now_hour,
  input  logic [MIN_W-1:0]  now_min,
  input  logic [SEC_W-1:0]  now_sec,
  input  logic [DOW_W-1:0]  now_dow,
  input  logic              cfg_we,
  input  logic [HOUR_W-1:0] cfg_hour,
  input  logic [MIN_W-1:0]  cfg_min,
  input  logic [DAYS_W-1:0] cfg_days,
  input  logic              cfg_en,
  input  logic              ack,
  input  logic              snooze,
  output logic              ring,
  output logic              snoozed
);
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int CD_W = $clog2(SNOOZE_TICKS + 1);
  localparam int RT_W = $clog2(RING_SECS + 1);
  localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  alarm_state_t      state;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [DAYS_W-1:0] days;
  logic [CD_W-1:0]   countdown;
  logic [RT_W-1:0]   ring_timer;
  logic [SC_W-1:0]   snooze_cnt;

  logic match;
  logic ring_finish;

  assign match = tick_1hz && (now_sec == '0) && (now_hour == hour) && (now_min == min) &&
                 ((days == '0) || ((days & (DAYS_W'(1) << now_dow)) != '0));

  // Ack, a snooze past the allowance, or the tick that reaches the timeout all end the ring.
  assign ring_finish = ack || (snooze && (snooze_cnt == SC_W'(MAX_SNOOZE))) ||
                       (!snooze && tick_1hz && (ring_timer == RT_W'(RING_SECS - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_OFF;
      hour       <= '0;
      min        <= '0;
      days       <= '0;
      countdown  <= '0;
      ring_timer <= '0;
      snooze_cnt <= '0;
      ring       <= 1'b0;
      snoozed    <= 1'b0;
    end else if (cfg_we) begin
      hour       <= cfg_hour;
      min        <= cfg_min;
      days       <= cfg_days;
      state      <= cfg_en ? ST_ARMED : ST_OFF;
      countdown  <= '0;
      ring_timer <= '0;
      snooze_cnt <= '0;
      ring       <= 1'b0;
      snoozed    <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (match) begin
            state      <= ST_RINGING;
            ring_timer <= '0;
            ring       <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (ring_finish) begin
            state      <= (days == '0) ? ST_OFF : ST_ARMED;
            snooze_cnt <= '0;
            ring       <= 1'b0;
            snoozed    <= 1'b0;
          end else if (snooze) begin
            state      <= ST_SNOOZED;
            countdown  <= CD_W'(SNOOZE_TICKS);
            snooze_cnt <= snooze_cnt + SC_W'(1);
            ring       <= 1'b0;
            snoozed    <= 1'b1;
          end else if (tick_1hz) begin
            ring_timer <= ring_timer + RT_W'(1);
          end
        end
        ST_SNOOZED: begin
          if (ack) begin
            state      <= (days == '0) ? ST_OFF : ST_ARMED;
            snooze_cnt <= '0;
            ring       <= 1'b0;
            snoozed    <= 1'b0;
          end else if (tick_1hz) begin
            if (countdown == CD_W'(1)) begin
              state      <= ST_RINGING;
              countdown  <= '0;
              ring_timer <= '0;
              ring       <= 1'b1;
              snoozed    <= 1'b0;
            end else begin
              countdown <= countdown - CD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm scheduler: broadcasts time and controls to N_CH channels,
// decodes per-channel config writes and reports the lowest ringing channel.
module alarm_bank
  import calendar_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60,
  parameter int MAX_SNOOZE = 3,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] now_hour,
  input  logic [MIN_W-1:0]  now_min,
  input  logic [SEC_W-1:0]  now_sec,
  input  logic [DOW_W-1:0]  now_dow,
  alarm_bank_if.slave       cfg,
  output logic [N_CH-1:0]   ring,
  output logic [N_CH-1:0]   snoozed,
  output logic              any_ring,
  output logic [CH_W-1:0]   ring_ch
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SECS  (RING_SECS),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_ch (
      .clk      (CLOCK_50),
      .reset    (reset),
      .tick_1hz (tick_1hz),
      .now_hour (now_hour),
      .now_min  (now_min),
      .now_sec  (now_sec),
      .now_dow  (now_dow),
      .cfg_we   (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))),
      .cfg_hour (cfg.cfg_hour),
      .cfg_min  (cfg.cfg_min),
      .cfg_days (cfg.cfg_days),
      .cfg_en   (cfg.cfg_en),
      .ack      (cfg.ack),
      .snooze   (cfg.snooze),
      .ring     (ring[i]),
      .snoozed  (snoozed[i])
    );
  end

  assign any_ring = |ring;

  // Scan downward so the lowest ringing index is the last one written.
  always_comb begin
    ring_ch = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (ring[i-1]) ring_ch = CH_W'(i - 1);
    end
  end
endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: a vector table for single events plus
// hand-written sequences for timeout, snooze, reconfigure and reset.
module tb_alarm_bank;
  import calendar_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] now_hour;
  logic [5:0] now_min;
  logic [5:0] now_sec;
  logic [2:0] now_dow;
  logic [3:0] ring;
  logic [3:0] snoozed;
  logic       any_ring;
  logic [1:0] ring_ch;

  int passed = 0;
  int total  = 0;

  alarm_bank_if #(.N_CH(4)) bus ();

  alarm_bank #(
    .N_CH       (4),
    .SNOOZE_MIN (1),
    .RING_SECS  (10),
    .MAX_SNOOZE (2)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .now_hour (now_hour),
    .now_min  (now_min),
    .now_sec  (now_sec),
    .now_dow  (now_dow),
    .cfg      (bus),
    .ring     (ring),
    .snoozed  (snoozed),
    .any_ring (any_ring),
    .ring_ch  (ring_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    int         h, m, s, d;
    logic       ack, snz;
    logic [3:0] ring, snzd;
    logic [1:0] ch;
  } vec_t;

  vec_t tab [14];

  function automatic vec_t v(input logic t, input int h, m, s, d, input logic a, sn,
                             input logic [3:0] r, sz, input logic [1:0] c);
    vec_t x;
    x.tick = t; x.h = h; x.m = m; x.s = s; x.d = d;
    x.ack = a; x.snz = sn; x.ring = r; x.snzd = sz; x.ch = c;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk(input string nm, input logic [3:0] er, input logic [3:0] es,
                     input logic [1:0] ec);
    cmp($sformatf("%s.ring", nm), ring, er);
    cmp($sformatf("%s.snoozed", nm), snoozed, es);
    cmp($sformatf("%s.any_ring", nm), {3'b000, any_ring}, {3'b000, |er});
    cmp($sformatf("%s.ring_ch", nm), {2'b00, ring_ch}, {2'b00, ec});
  endtask

  // Three idle cycles then one event cycle; returns just after the event edge.
  task automatic ev(input logic t, input int h, m, s, d, input logic a, sn);
    tick_1hz = 1'b0;
    repeat (3) step();
    now_hour = 5'(h); now_min = 6'(m); now_sec = 6'(s); now_dow = 3'(d);
    tick_1hz = t; bus.ack = a; bus.snooze = sn;
    step();
    tick_1hz = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
  endtask

  task automatic filler();
    ev(1'b1, 12, 34, 56, 0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input int ch, h, m, input logic [6:0] days, input logic en);
    bus.cfg_ch = 2'(ch); bus.cfg_hour = 5'(h); bus.cfg_min = 6'(m);
    bus.cfg_days = days; bus.cfg_en = en; bus.cfg_we = 1'b1;
    step();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick_1hz = 1'b0;
    now_hour = '0; now_min = '0; now_sec = '0; now_dow = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_hour = '0; bus.cfg_min = '0;
    bus.cfg_days = '0; bus.cfg_en = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset", 4'b0000, 4'b0000, 2'd0);

    cfg_write(1, 7, 30, 7'b0111110, 1'b1);
    cfg_write(0, 8, 0, 7'b0000000, 1'b1);
    cfg_write(3, 8, 0, 7'b0000000, 1'b1);

    tab[0]  = v(1, 7, 29, 59, 1, 0, 0, 4'b0000, 4'b0000, 2'd0);
    tab[1]  = v(1, 7, 30,  0, 1, 0, 0, 4'b0010, 4'b0000, 2'd1);
    tab[2]  = v(0, 7, 30,  1, 1, 1, 0, 4'b0000, 4'b0000, 2'd0);
    tab[3]  = v(1, 7, 30,  0, 6, 0, 0, 4'b0000, 4'b0000, 2'd0);
    tab[4]  = v(1, 7, 30,  0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
    tab[5]  = v(1, 7, 30,  0, 2, 0, 0, 4'b0010, 4'b0000, 2'd1);
    tab[6]  = v(1, 7, 31,  0, 2, 0, 0, 4'b0010, 4'b0000, 2'd1);
    tab[7]  = v(0, 7, 31,  1, 2, 1, 0, 4'b0000, 4'b0000, 2'd0);
    tab[8]  = v(1, 8,  0,  0, 3, 0, 0, 4'b1001, 4'b0000, 2'd0);
    tab[9]  = v(0, 8,  0,  1, 3, 1, 0, 4'b0000, 4'b0000, 2'd0);
    tab[10] = v(1, 8,  0,  0, 4, 0, 0, 4'b0000, 4'b0000, 2'd0);
    tab[11] = v(1, 7, 30,  0, 3, 0, 0, 4'b0010, 4'b0000, 2'd1);
    tab[12] = v(0, 7, 30,  1, 3, 0, 1, 4'b0000, 4'b0010, 2'd0);
    tab[13] = v(0, 7, 30,  2, 3, 1, 0, 4'b0000, 4'b0000, 2'd0);

    for (int i = 0; i < 14; i++) begin
      ev(tab[i].tick, tab[i].h, tab[i].m, tab[i].s, tab[i].d, tab[i].ack, tab[i].snz);
      chk($sformatf("vec%0d", i), tab[i].ring, tab[i].snzd, tab[i].ch);
    end

    // One-shot ring timeout, then no re-fire the next day.
    cfg_write(0, 0, 1, 7'b0000000, 1'b1);
    ev(1'b1, 0, 1, 0, 0, 1'b0, 1'b0);
    chk("oneshot_fire", 4'b0001, 4'b0000, 2'd0);
    for (int i = 1; i <= 9; i++) filler();
    chk("timeout_tick9", 4'b0001, 4'b0000, 2'd0);
    filler();
    chk("timeout_tick10", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 0, 1, 0, 1, 1'b0, 1'b0);
    chk("oneshot_nextday", 4'b0000, 4'b0000, 2'd0);

    // Snooze twice with full-length countdowns; third snooze finishes.
    cfg_write(2, 6, 0, 7'b1111111, 1'b1);
    ev(1'b1, 6, 0, 0, 5, 1'b0, 1'b0);
    chk("daily_fire", 4'b0100, 4'b0000, 2'd2);
    for (int k = 0; k < 2; k++) begin
      ev(1'b0, 6, 0, 1, 5, 1'b0, 1'b1);
      chk($sformatf("snooze%0d", k), 4'b0000, 4'b0100, 2'd0);
      for (int i = 1; i <= 59; i++) begin
        filler();
        if (k == 0 && i == 30) begin
          ev(1'b0, 12, 34, 56, 0, 1'b0, 1'b1);
          chk("snooze_while_snoozed", 4'b0000, 4'b0100, 2'd0);
        end
      end
      chk($sformatf("snooze%0d_tick59", k), 4'b0000, 4'b0100, 2'd0);
      filler();
      chk($sformatf("snooze%0d_tick60", k), 4'b0100, 4'b0000, 2'd2);
    end
    ev(1'b0, 6, 2, 1, 5, 1'b0, 1'b1);
    chk("snooze_limit", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 6, 0, 0, 6, 1'b0, 1'b0);
    chk("rearmed_after_limit", 4'b0100, 4'b0000, 2'd2);

    // Reconfigure a snoozed channel as disabled.
    ev(1'b0, 6, 0, 1, 6, 1'b0, 1'b1);
    chk("snooze_again", 4'b0000, 4'b0100, 2'd0);
    cfg_write(2, 6, 0, 7'b1111111, 1'b0);
    chk("cfg_abort", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 6, 0, 0, 0, 1'b0, 1'b0);
    chk("cfg_disabled", 4'b0000, 4'b0000, 2'd0);

    // Ack and snooze together: ack wins.
    cfg_write(3, 9, 15, 7'b0000000, 1'b1);
    ev(1'b1, 9, 15, 0, 0, 1'b0, 1'b0);
    chk("ch3_fire", 4'b1000, 4'b0000, 2'd3);
    ev(1'b0, 9, 15, 1, 0, 1'b1, 1'b1);
    chk("ack_beats_snooze", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 9, 15, 0, 1, 1'b0, 1'b0);
    chk("ack_consumed_oneshot", 4'b0000, 4'b0000, 2'd0);

    // Reset mid-snooze clears state and configuration.
    cfg_write(0, 10, 0, 7'b0000000, 1'b1);
    cfg_write(3, 10, 0, 7'b1111111, 1'b1);
    ev(1'b1, 10, 0, 0, 2, 1'b0, 1'b0);
    chk("pair_fire", 4'b1001, 4'b0000, 2'd0);
    ev(1'b0, 10, 0, 1, 2, 1'b0, 1'b1);
    chk("pair_snoozed", 4'b0000, 4'b1001, 2'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_snooze", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 10, 0, 0, 2, 1'b0, 1'b0);
    chk("reset_cleared_cfg", 4'b0000, 4'b0000, 2'd0);
    ev(1'b1, 7, 30, 0, 2, 1'b0, 1'b0);
    chk("reset_cleared_ch1", 4'b0000, 4'b0000, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm scheduler for the calendar design. It watches the running time-of-day and day-of-week and raises per-channel ring outputs on programmed matches. It supports one-shot and weekday-mask repeats, snooze with a bounded snooze count, and automatic ring timeout. It sits beside the clock/date counters, consumes their current-time buses and 1 Hz strobe, and drives LEDs or a buzzer through the output module.

## Interface
Parameters:
- N_CH, 4, number of independent alarm channels (1..16)
- SNOOZE_MIN, 5, snooze length in minutes (1..30)
- RING_SECS, 60, ring auto-stop timeout in seconds (1..255)
- MAX_SNOOZE, 3, snoozes allowed per firing; the next snooze acts as ack

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- tick_1hz  in  1  one-cycle strobe once per second, aligned with now_* update
- now_hour  in  5  current hour, 0..23 binary
- now_min  in  6  current minute, 0..59
- now_sec  in  6  current second, 0..59
- now_dow  in  3  day of week, 0=Sun..6=Sat
- cfg_we  in  1  write strobe for channel cfg_ch
- cfg_ch  in  $clog2(N_CH) (min 1)  channel index
- cfg_hour  in  5  alarm hour
- cfg_min  in  6  alarm minute
- cfg_days  in  7  weekday mask, bit d = now_dow d; 0 = one-shot
- cfg_en  in  1  arm on write
- ack  in  1  one-cycle pulse: stop all ringing and snoozed channels
- snooze  in  1  one-cycle pulse: snooze all ringing channels
- ring  out  N_CH  channel in RINGING
- snoozed  out  N_CH  channel in SNOOZED
- any_ring  out  1  OR of ring
- ring_ch  out  $clog2(N_CH) (min 1)  lowest ringing index; 0 when none

## Operation
- Per-channel FSM with states OFF, ARMED, RINGING, SNOOZED. After reset every channel is OFF, and all outputs, timers and snooze counters are 0.
- match = tick_1hz && now_sec==0 && now_hour==hour && now_min==min && (days==0 || days[now_dow]).
- Event priority within one channel, highest first: reset, cfg_we to that channel, ack, snooze, tick/match.
- cfg_we: load hour/min/days. State becomes ARMED if cfg_en, else OFF. Timers and snooze_cnt are cleared. A write aborts any ring or snooze in progress.
- ARMED:
  - match -> RINGING, ring_timer=0.
  - Matches in any other state are ignored.
- RINGING:
  - ack -> finish.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZED, countdown=SNOOZE_MIN*60, snooze_cnt+1.
  - snooze with snooze_cnt==MAX_SNOOZE -> finish.
  - tick: ring_timer+1; reaching RING_SECS -> finish.
- SNOOZED:
  - ack -> finish.
  - snooze is ignored.
  - tick: countdown-1; 1->0 -> RINGING, ring_timer=0.
- finish: snooze_cnt=0; days==0 -> OFF (one-shot consumed), else ARMED.
- A re-fire on the same minute is impossible: a channel that finishes within minute M re-arms, but now_sec==0 of M has already passed.
- Unused cfg_ch values (>=N_CH) are ignored.
- Counter widths: countdown is $clog2(SNOOZE_MIN*60+1), ring_timer is $clog2(RING_SECS+1), snooze_cnt is $clog2(MAX_SNOOZE+1). No wrap is possible within legal ranges.

## Timing
- All outputs are registered.
- A match or event sampled at edge t is reflected on ring/snoozed/any_ring/ring_ch after edge t (visible in cycle t+1).
- Ack/snooze pulses take effect in one cycle; holding them longer is harmless, since ack is idempotent and snooze applies only to RINGING.
- A snooze countdown expiring on tick t rings from t+1. Total snooze duration is exactly SNOOZE_MIN*60 ticks.
- Ring timeout: ring is high for exactly RING_SECS ticks when unattended.
- Reset mid-ring or mid-snooze: all channels OFF on the next cycle, and configuration is cleared.

## Structure
- Shared package calendar_pkg holds:
  - the alarm state enum
  - width constants HOUR_W=5, MIN_W=6, SEC_W=6, DOW_W=3
  - DOW encoding constants SUN..SAT
  - the packed date layout year[22:9]/month[8:5]/day[4:0], for other calendar blocks
- Sub-module alarm_channel holds one FSM with its config registers and timers; it is generate-instantiated N_CH times.
- The top holds broadcast wiring, per-channel write decode, and the lowest-index priority encoder for ring_ch.

## Test plan
Bench uses N_CH=4, SNOOZE_MIN=1, RING_SECS=10, MAX_SNOOZE=2, with tick_1hz every 4 cycles.
- Ch1 armed 07:30 days=0111110; drive Mon(1) 07:29:59 -> 07:30:00 tick -> ring=0010 and ring_ch=1 next cycle; Sat 07:30:00 -> no ring.
- Ch0 one-shot 00:01; fire, then 10 ticks without ack -> ring drops after tick 10; state OFF; next day 00:01 -> no ring.
- Ch2 ringing; snooze -> snoozed=0100; after 60 ticks it rings again; repeat twice; third snooze -> finish, ring=0, ARMED.
- Ch0 and ch3 fire on the same tick -> ring=1001, ring_ch=0; single ack -> ring=0000 next cycle.
- cfg_we to ch2 while it is SNOOZED with cfg_en=0 -> snoozed=0, OFF. Reset asserted while ringing -> all outputs 0 next cycle.
- ack and snooze asserted in the same cycle on a ringing channel -> ack wins, no SNOOZED entry.
